// File: rtl/rram_ctrl_pkg.sv
// Purpose : shared types and constants for the RRAM array sequencer.
// Contents: command opcodes, sequencer states, one-hot level selects,
//           per-line drive encodings ({IN1,IN0} per line) and the bundle
//           of registered array-side controls.
package rram_ctrl_pkg;

    localparam int ROWS = 16;
    localparam int COLS = 16;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_MAC   = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_RESET = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRE,
        ST_DRIVE,
        ST_SENSE,
        ST_ADC_A,
        ST_ADC_B,
        ST_PULSE,
        ST_RECOV,
        ST_RESP
    } state_t;

    // Level select, bit n selects V(n+1).
    localparam logic [3:0] LVL_OFF = 4'b0000;
    localparam logic [3:0] LVL_V1  = 4'b0001;
    localparam logic [3:0] LVL_V2  = 4'b0010;
    localparam logic [3:0] LVL_V3  = 4'b0100;
    localparam logic [3:0] LVL_V4  = 4'b1000;

    // Per line: in1=1,in0=0 drive level; in1=0,in0=1 ground; 00 float.
    typedef struct packed {
        logic [ROWS-1:0] in1;
        logic [ROWS-1:0] in0;
    } lines_t;

    localparam lines_t LINES_FLOAT = '{in1: '0, in0: '0};
    localparam lines_t LINES_GND   = '{in1: '0, in0: '1};
    localparam lines_t LINES_LEVEL = '{in1: '1, in0: '0};

    typedef struct packed {
        logic       en_wl;
        logic       en_bl;
        logic       en_sl;
        logic [3:0] lvl_wl;
        logic [3:0] lvl_bl;
        logic [3:0] lvl_sl;
        lines_t     wl;
        lines_t     bl;
        lines_t     sl;
        logic       pre;
        logic       en_csa;
        logic       saen_csa;
        logic       ref_csa;
        logic [1:0] clk_en_adc;
        logic [2:0] ref_adc;
    } arr_ctl_t;

    // Selected lines at level, every other line grounded; never yields 11.
    function automatic lines_t drive_sel(input logic [ROWS-1:0] mask);
        lines_t l;
        l.in1 = mask;
        l.in0 = ~mask;
        return l;
    endfunction

    function automatic logic row_is_onehot(input logic [ROWS-1:0] row);
        return (row != '0) && ((row & (row - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/rram_adc_decode.sv
// Purpose : per-column decode of the 3-bit thermometer ADC result.
// Ports   : i_out0..i_out2  thermometer bits, one bit per column
//           o_counts        2-bit count per column, column i at [2i+1:2i]
//           o_err           any column holding a non-thermometer code
module rram_adc_decode
    import rram_ctrl_pkg::*;
(
    input  logic [COLS-1:0]   i_out0,
    input  logic [COLS-1:0]   i_out1,
    input  logic [COLS-1:0]   i_out2,
    output logic [2*COLS-1:0] o_counts,
    output logic              o_err
);

    always_comb begin
        o_counts = '0;
        o_err    = 1'b0;
        for (int i = 0; i < COLS; i++) begin
            o_counts[2*i +: 2] = {1'b0, i_out0[i]} + {1'b0, i_out1[i]} + {1'b0, i_out2[i]};
            // Legal codes are 000/001/011/111: a set bit needs the one below it.
            if ((i_out1[i] & ~i_out0[i]) | (i_out2[i] & ~i_out1[i]))
                o_err = 1'b1;
        end
    end

endmodule

// File: rtl/rram_seq_ctrl.sv
// Purpose : command sequencer in front of the 16x16 RRAM macro. Accepts
//           READ/MAC/SET/RESET, steps the macro through timed phases and
//           returns one response per command.
// Ports   : i_cmd_*  command handshake, op, row mask, column mask
//           o_rsp_*  response handshake, data, error
//           o_enable_*, o_v*_*, o_in1_*, o_in0_*  line drivers
//           o_pre, o_*_csa, o_clk_en_adc, o_v*_ref_adc  analog controls
//           i_csa, i_adc_out*  sense-amp and ADC results
// All outputs are flops loaded from the next-state decode, so each phase's
// controls appear exactly with that phase and nothing combinational leaves.
module rram_seq_ctrl
    import rram_ctrl_pkg::*;
#(
    parameter int PRE_CYC    = 4,
    parameter int SETTLE_CYC = 2,
    parameter int PULSE_CYC  = 8,
    parameter int ADC_CYC    = 2,
    parameter int CNT_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [1:0]       i_cmd_op,
    input  logic [ROWS-1:0]  i_cmd_row,
    input  logic [COLS-1:0]  i_cmd_col,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [31:0]      o_rsp_data,
    output logic             o_rsp_err,
    output logic             o_enable_wl,
    output logic             o_enable_bl,
    output logic             o_enable_sl,
    output logic             o_v1_wl, o_v2_wl, o_v3_wl, o_v4_wl,
    output logic             o_v1_bl, o_v2_bl, o_v3_bl, o_v4_bl,
    output logic             o_v1_sl, o_v2_sl, o_v3_sl, o_v4_sl,
    output logic [ROWS-1:0]  o_in1_wl,
    output logic [ROWS-1:0]  o_in0_wl,
    output logic [COLS-1:0]  o_in1_bl,
    output logic [COLS-1:0]  o_in0_bl,
    output logic [COLS-1:0]  o_in1_sl,
    output logic [COLS-1:0]  o_in0_sl,
    output logic             o_pre,
    output logic             o_enable_csa,
    output logic             o_saen_csa,
    output logic             o_ref_csa,
    output logic [1:0]       o_clk_en_adc,
    output logic             o_v0_ref_adc,
    output logic             o_v1_ref_adc,
    output logic             o_v2_ref_adc,
    input  logic [COLS-1:0]  i_csa,
    input  logic [COLS-1:0]  i_adc_out0,
    input  logic [COLS-1:0]  i_adc_out1,
    input  logic [COLS-1:0]  i_adc_out2
);

    state_t          r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]      r_op;
    logic [ROWS-1:0] r_row;
    logic [COLS-1:0] r_col;
    arr_ctl_t        r_ctl, w_ctl;
    logic            r_cmd_ready, r_rsp_valid, r_rsp_err;
    logic [31:0]     r_rsp_data;

    logic            w_accept, w_illegal, w_cnt_done, w_adc_err;
    logic [1:0]      w_op_nxt;
    logic [ROWS-1:0] w_row_nxt;
    logic [COLS-1:0] w_col_nxt;
    logic [31:0]     w_adc_counts;

    rram_adc_decode u_adc_decode (
        .i_out0   (i_adc_out0),
        .i_out1   (i_adc_out1),
        .i_out2   (i_adc_out2),
        .o_counts (w_adc_counts),
        .o_err    (w_adc_err)
    );

    assign w_accept   = (r_state == ST_IDLE) && r_cmd_ready && i_cmd_valid;
    assign w_illegal  = (i_cmd_op != OP_MAC) && !row_is_onehot(i_cmd_row);
    assign w_cnt_done = (r_cnt == '0);
    assign w_op_nxt   = w_accept ? i_cmd_op  : r_op;
    assign w_row_nxt  = w_accept ? i_cmd_row : r_row;
    assign w_col_nxt  = w_accept ? i_cmd_col : r_col;

    // Phase timer counts down from length-1; the phase ends at zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_cnt_done ? '0 : r_cnt - 1'b1;
        case (r_state)
            ST_IDLE: if (w_accept) begin
                if (w_illegal) begin
                    w_state_nxt = ST_RESP;
                end else if (i_cmd_op == OP_READ || i_cmd_op == OP_MAC) begin
                    w_state_nxt = ST_PRE;
                    w_cnt_nxt   = CNT_W'(PRE_CYC - 1);
                end else begin
                    w_state_nxt = ST_PULSE;
                    w_cnt_nxt   = CNT_W'(PULSE_CYC - 1);
                end
            end
            ST_PRE: if (w_cnt_done) begin
                w_state_nxt = ST_DRIVE;
                w_cnt_nxt   = CNT_W'(SETTLE_CYC - 1);
            end
            ST_DRIVE: if (w_cnt_done) begin
                w_state_nxt = (r_op == OP_MAC) ? ST_ADC_A : ST_SENSE;
                w_cnt_nxt   = (r_op == OP_MAC) ? CNT_W'(ADC_CYC - 1) : '0;
            end
            ST_SENSE: w_state_nxt = ST_RESP;
            ST_ADC_A: if (w_cnt_done) begin
                w_state_nxt = ST_ADC_B;
                w_cnt_nxt   = CNT_W'(ADC_CYC - 1);
            end
            ST_ADC_B: if (w_cnt_done) w_state_nxt = ST_RESP;
            ST_PULSE: if (w_cnt_done) begin
                w_state_nxt = ST_RECOV;
                w_cnt_nxt   = CNT_W'(SETTLE_CYC - 1);
            end
            ST_RECOV: if (w_cnt_done) w_state_nxt = ST_RESP;
            ST_RESP:  if (r_rsp_valid && i_rsp_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Array controls for the state being entered. The read path stays driven
    // through both ADC phases so the column current is held while converting.
    always_comb begin
        w_ctl    = '0;
        w_ctl.wl = LINES_FLOAT;
        w_ctl.bl = LINES_FLOAT;
        w_ctl.sl = LINES_FLOAT;
        case (w_state_nxt)
            ST_PRE: w_ctl.pre = 1'b1;
            ST_DRIVE, ST_SENSE, ST_ADC_A, ST_ADC_B: begin
                w_ctl.en_wl  = 1'b1;
                w_ctl.en_bl  = 1'b1;
                w_ctl.en_sl  = 1'b1;
                w_ctl.lvl_wl = LVL_V1;
                w_ctl.lvl_bl = LVL_V1;
                w_ctl.lvl_sl = LVL_V1;
                w_ctl.wl     = drive_sel(w_row_nxt);
                w_ctl.bl     = LINES_LEVEL;
                w_ctl.sl     = LINES_GND;
                if (w_op_nxt == OP_MAC) begin
                    w_ctl.ref_adc = 3'b111;
                end else begin
                    w_ctl.ref_csa = 1'b1;
                    w_ctl.en_csa  = 1'b1;
                end
                w_ctl.saen_csa   = (w_state_nxt == ST_SENSE);
                w_ctl.clk_en_adc = (w_state_nxt == ST_ADC_A) ? 2'b01 :
                                   (w_state_nxt == ST_ADC_B) ? 2'b10 : 2'b00;
            end
            ST_PULSE: begin
                w_ctl.en_wl  = 1'b1;
                w_ctl.en_bl  = 1'b1;
                w_ctl.en_sl  = 1'b1;
                w_ctl.lvl_wl = LVL_V2;
                w_ctl.wl     = drive_sel(w_row_nxt);
                if (w_op_nxt == OP_SET) begin
                    w_ctl.lvl_bl = LVL_V4;
                    w_ctl.bl     = drive_sel(w_col_nxt);
                    w_ctl.sl     = LINES_GND;
                end else begin
                    w_ctl.lvl_sl = LVL_V4;
                    w_ctl.sl     = drive_sel(w_col_nxt);
                    w_ctl.bl     = LINES_GND;
                end
            end
            default: w_ctl.lvl_wl = LVL_OFF;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_op        <= OP_READ;
            r_row       <= '0;
            r_col       <= '0;
            r_ctl       <= '0;
            r_cmd_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ctl       <= w_ctl;
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            if (w_accept) begin
                r_op       <= i_cmd_op;
                r_row      <= i_cmd_row;
                r_col      <= i_cmd_col;
                r_rsp_data <= '0;
                r_rsp_err  <= w_illegal;
            end else if (r_state == ST_SENSE) begin
                r_rsp_data <= {16'b0, i_csa};
            end else if (r_state == ST_ADC_B && w_cnt_done) begin
                r_rsp_data <= w_adc_counts;
                r_rsp_err  <= w_adc_err;
            end
        end
    end

    assign o_cmd_ready  = r_cmd_ready;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_data   = r_rsp_data;
    assign o_rsp_err    = r_rsp_err;
    assign o_enable_wl  = r_ctl.en_wl;
    assign o_enable_bl  = r_ctl.en_bl;
    assign o_enable_sl  = r_ctl.en_sl;
    assign {o_v4_wl, o_v3_wl, o_v2_wl, o_v1_wl} = r_ctl.lvl_wl;
    assign {o_v4_bl, o_v3_bl, o_v2_bl, o_v1_bl} = r_ctl.lvl_bl;
    assign {o_v4_sl, o_v3_sl, o_v2_sl, o_v1_sl} = r_ctl.lvl_sl;
    assign o_in1_wl     = r_ctl.wl.in1;
    assign o_in0_wl     = r_ctl.wl.in0;
    assign o_in1_bl     = r_ctl.bl.in1;
    assign o_in0_bl     = r_ctl.bl.in0;
    assign o_in1_sl     = r_ctl.sl.in1;
    assign o_in0_sl     = r_ctl.sl.in0;
    assign o_pre        = r_ctl.pre;
    assign o_enable_csa = r_ctl.en_csa;
    assign o_saen_csa   = r_ctl.saen_csa;
    assign o_ref_csa    = r_ctl.ref_csa;
    assign o_clk_en_adc = r_ctl.clk_en_adc;
    assign {o_v2_ref_adc, o_v1_ref_adc, o_v0_ref_adc} = r_ctl.ref_adc;

endmodule
